// File: rtl/bb_msg_scheduler.sv
// Bounding-box message scheduler: every MSG_INTERVAL frames it snapshots the per-colour boxes and streams header/TL/BR words plus an "EF" trailer.
// Optional build macro BB_MSG_SKIP_EMPTY_EN drops enabled colours whose box is empty (left > right or top > bottom).
module bb_msg_scheduler #(
    parameter int NUM_COLOURS  = 5,
    parameter int MSG_INTERVAL = 6,
    parameter int BUF_MAX      = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_done,
    input  logic [NUM_COLOURS*44-1:0] bbox_in,
    input  logic [NUM_COLOURS-1:0]    colour_en,
    input  logic                      flush,
    input  logic [7:0]                buf_size,
    output logic                      buf_wr,
    output logic [31:0]               buf_data,
    output logic                      busy,
    output logic [7:0]                dropped
);
    localparam int CI_W = (NUM_COLOURS > 1) ? $clog2(NUM_COLOURS) : 1;
    localparam logic [8:0] HDR_LIM = 9'(BUF_MAX - 5);
    localparam logic [8:0] TRL_LIM = 9'(BUF_MAX - 2);

    typedef enum logic [2:0] {IDLE, HDR, TL, BR, GAP, TRL} state_t;

    state_t                    state, state_nxt;
    logic [CI_W-1:0]           ci, ci_nxt, ci_v;
    logic [7:0]                fcnt, fcnt_nxt, seq, seq_nxt, dropped_nxt;
    logic                      wr_nxt;
    logic [31:0]               data_nxt;
    logic [NUM_COLOURS*44-1:0] bbox_q, bbox_v;
    logic [NUM_COLOURS-1:0]    en_q, en_v, en_live;
    logic [43:0]               box;
    logic                      start, more;
    logic                      room_hdr, room_trl;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

`ifdef BB_MSG_SKIP_EMPTY_EN
    function automatic logic box_empty(input logic [43:0] b);
        return (b[43:33] > b[32:22]) || (b[21:11] > b[10:0]);
    endfunction
`endif

    always_comb begin
        en_live = colour_en;
`ifdef BB_MSG_SKIP_EMPTY_EN
        for (int i = 0; i < NUM_COLOURS; i++)
            if (box_empty(bbox_in[44*i +: 44])) en_live[i] = 1'b0;
`endif
    end

    assign start    = frame_done && !flush && (state == IDLE) && (fcnt == 8'd0);
    assign room_hdr = {1'b0, buf_size} <= HDR_LIM;
    assign room_trl = {1'b0, buf_size} <= TRL_LIM;
    assign busy     = (state != IDLE);

    // The starting frame is evaluated as colour 0's header directly from the live
    // inputs so the first word is registered on the same edge that sees frame_done.
    always_comb begin
        en_v   = start ? en_live : en_q;
        bbox_v = start ? bbox_in : bbox_q;
        ci_v   = start ? '0 : ci;
        box    = bbox_v[44*int'(ci_v) +: 44];
        more   = 1'b0;
        for (int i = 0; i < NUM_COLOURS; i++)
            if (i > int'(ci_v) && en_v[i]) more = 1'b1;
    end

    always_comb begin
        state_nxt   = state;
        ci_nxt      = ci;
        fcnt_nxt    = fcnt;
        seq_nxt     = seq;
        dropped_nxt = dropped;
        wr_nxt      = 1'b0;
        data_nxt    = buf_data;

        if (frame_done && !flush) begin
            if (fcnt != 8'd0)       fcnt_nxt    = fcnt - 8'd1;
            else if (state == IDLE) fcnt_nxt    = 8'(MSG_INTERVAL - 1);
            else                    dropped_nxt = sat_inc8(dropped);
        end

        if (flush) begin
            state_nxt = IDLE;
            ci_nxt    = '0;
        end else if (start || state == HDR) begin
            ci_nxt = ci_v;
            if (!en_v[ci_v]) begin
                if (more) begin
                    ci_nxt    = ci_v + CI_W'(1);
                    state_nxt = HDR;
                end else begin
                    state_nxt = TRL;
                end
            end else if (room_hdr) begin
                wr_nxt    = 1'b1;
                data_nxt  = {8'h00, 8'h42, 8'h42, 8'h30 + 8'(ci_v)};
                state_nxt = TL;
            end else begin
                state_nxt = HDR;
            end
        end else begin
            case (state)
                TL: begin
                    wr_nxt    = 1'b1;
                    data_nxt  = {5'b0, box[43:33], 5'b0, box[21:11]};
                    state_nxt = BR;
                end
                BR: begin
                    wr_nxt    = 1'b1;
                    data_nxt  = {5'b0, box[32:22], 5'b0, box[10:0]};
                    state_nxt = GAP;
                end
                GAP: begin
                    if (more) begin
                        ci_nxt    = ci + CI_W'(1);
                        state_nxt = HDR;
                    end else begin
                        state_nxt = TRL;
                    end
                end
                TRL: begin
                    if (room_trl) begin
                        wr_nxt    = 1'b1;
                        data_nxt  = {8'h00, 8'h45, 8'h46, seq};
                        seq_nxt   = seq + 8'd1;
                        ci_nxt    = '0;
                        state_nxt = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ci       <= '0;
            fcnt     <= 8'd0;
            seq      <= 8'd0;
            dropped  <= 8'd0;
            buf_wr   <= 1'b0;
            buf_data <= 32'd0;
        end else begin
            state    <= state_nxt;
            ci       <= ci_nxt;
            fcnt     <= fcnt_nxt;
            seq      <= seq_nxt;
            dropped  <= dropped_nxt;
            buf_wr   <= wr_nxt;
            buf_data <= data_nxt;
        end
    end

    // Snapshot is pure data: only captured when a batch starts.
    always_ff @(posedge clk) begin
        if (start) begin
            bbox_q <= bbox_in;
            en_q   <= en_live;
        end
    end
endmodule

// File: tb/tb_bb_msg_scheduler.sv
// Directed testbench for bb_msg_scheduler: captures every FIFO write with its cycle number and compares against hand-computed words.
module tb_bb_msg_scheduler;
    localparam int NC = 5;

    logic            clk = 1'b0;
    logic            rst, frame_done, flush;
    logic [NC*44-1:0] bbox_in;
    logic [NC-1:0]   colour_en;
    logic [7:0]      buf_size;
    logic            buf_wr, busy;
    logic [31:0]     buf_data;
    logic [7:0]      dropped;

    bb_msg_scheduler #(.NUM_COLOURS(NC), .MSG_INTERVAL(6), .BUF_MAX(256)) dut (
        .clk(clk), .rst(rst), .frame_done(frame_done), .bbox_in(bbox_in),
        .colour_en(colour_en), .flush(flush), .buf_size(buf_size),
        .buf_wr(buf_wr), .buf_data(buf_data), .busy(busy), .dropped(dropped)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] wq[$];
    int          tq[$];
    always @(negedge clk) begin
        if (buf_wr) begin
            wq.push_back(buf_data);
            tq.push_back(cyc);
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qw(input int i);
        return (i < wq.size()) ? wq[i] : 32'hDEADBEEF;
    endfunction

    function automatic int qt(input int i);
        return (i < tq.size()) ? tq[i] : -1000;
    endfunction

    function automatic logic [43:0] box(input int l, input int r, input int t, input int b);
        return {11'(l), 11'(r), 11'(t), 11'(b)};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; frame_done = 1'b0; flush = 1'b0;
        step(2);
        rst = 1'b0;
        wq.delete();
        tq.delete();
    endtask

    task automatic pulse(output int at);
        frame_done = 1'b1;
        step(1);
        at = cyc;
        frame_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t0, n, set_cyc;
        rst = 1'b1; frame_done = 1'b0; flush = 1'b0;
        bbox_in = '0; colour_en = '0; buf_size = 8'd0;

        // Reset state and single-colour batch
        do_reset();
        check("rst_buf_wr", 32'(buf_wr), 32'd0);
        check("rst_buf_data", buf_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dropped", 32'(dropped), 32'd0);
        colour_en = 5'b00001;
        bbox_in[0 +: 44] = box(10, 20, 30, 40);
        pulse(t0);
        step(10);
        check("b1_count", 32'(wq.size()), 32'd4);
        check("b1_hdr", qw(0), 32'h00424230);
        check("b1_tl", qw(1), 32'h000A001E);
        check("b1_br", qw(2), 32'h00140028);
        check("b1_trl", qw(3), 32'h00454600);
        check("b1_lat", 32'(qt(0) - t0), 32'd0);
        check("b1_gap01", 32'(qt(1) - qt(0)), 32'd1);
        check("b1_gap12", 32'(qt(2) - qt(1)), 32'd1);
        check("b1_gap23", 32'(qt(3) - qt(2)), 32'd2);
        check("b1_idle", 32'(busy), 32'd0);

        // Batch cadence over 13 idle frames
        do_reset();
        for (int k = 1; k <= 13; k++) begin
            n = wq.size();
            pulse(t0);
            step(7);
            check($sformatf("cad_p%0d", k), 32'(wq.size() > n), 32'((k == 1) || (k == 7) || (k == 13)));
        end
        check("cad_count", 32'(wq.size()), 32'd12);
        check("cad_seq2", qw(11), 32'h00454602);

        // Header stall on FIFO level
        do_reset();
        buf_size = 8'd252;
        pulse(t0);
        step(9);
        check("stall_nowr", 32'(wq.size()), 32'd0);
        check("stall_busy", 32'(busy), 32'd1);
        buf_size = 8'd251;
        set_cyc = cyc + 1;
        step(6);
        check("stall_hdr", qw(0), 32'h00424230);
        check("stall_when", 32'(qt(0)), 32'(set_cyc));
        check("stall_count", 32'(wq.size()), 32'd4);
        buf_size = 8'd0;

        // Dropped batch while busy
        do_reset();
        bbox_in = '0;
        colour_en = 5'b00001;
        bbox_in[0 +: 44] = box(10, 20, 30, 40);
        buf_size = 8'd252;
        pulse(t0);
        step(1);
        bbox_in[0 +: 44] = box(1, 2, 3, 4);
        colour_en = 5'b00011;
        for (int k = 1; k <= 6; k++) begin
            pulse(t0);
            step(1);
            check($sformatf("drop_p%0d", k), 32'(dropped), 32'(k == 6));
        end
        check("drop_busy", 32'(busy), 32'd1);
        buf_size = 8'd0;
        step(12);
        check("drop_count", 32'(wq.size()), 32'd4);
        check("drop_hdr", qw(0), 32'h00424230);
        check("drop_tl", qw(1), 32'h000A001E);
        check("drop_br", qw(2), 32'h00140028);
        check("drop_trl", qw(3), 32'h00454600);
        check("drop_keep", 32'(dropped), 32'd1);

        // Flush in TL, then next batch from colour 0
        do_reset();
        bbox_in = '0;
        colour_en = 5'b00011;
        bbox_in[0 +: 44]  = box(10, 20, 30, 40);
        bbox_in[44 +: 44] = box(5, 6, 7, 8);
        pulse(t0);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        check("fl_wr", 32'(buf_wr), 32'd0);
        check("fl_busy", 32'(busy), 32'd0);
        check("fl_count", 32'(wq.size()), 32'd1);
        step(3);
        for (int k = 1; k <= 5; k++) begin
            pulse(t0);
            step(1);
        end
        check("fl_quiet", 32'(wq.size()), 32'd1);
        pulse(t0);
        step(14);
        check("fl_total", 32'(wq.size()), 32'd8);
        check("fl_hdr0", qw(1), 32'h00424230);
        check("fl_hdr1", qw(4), 32'h00424231);
        check("fl_tl1", qw(5), 32'h00050007);
        check("fl_br1", qw(6), 32'h00060008);
        check("fl_trl", qw(7), 32'h00454600);

        // Reset in the middle of a batch
        do_reset();
        bbox_in = '0;
        colour_en = 5'b00001;
        bbox_in[0 +: 44] = box(10, 20, 30, 40);
        pulse(t0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(6);
        check("mid_rst_count", 32'(wq.size()), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);

        // Empty box on colour 2
        do_reset();
        bbox_in = '0;
        colour_en = 5'b00100;
        bbox_in[88 +: 44] = box(100, 50, 7, 9);
        pulse(t0);
        step(10);
`ifdef BB_MSG_SKIP_EMPTY_EN
        check("empty_count", 32'(wq.size()), 32'd1);
        check("empty_trl", qw(0), 32'h00454600);
`else
        check("empty_count", 32'(wq.size()), 32'd4);
        check("empty_hdr", qw(0), 32'h00424232);
        check("empty_tl", qw(1), 32'h00640007);
        check("empty_br", qw(2), 32'h00320009);
        check("empty_trl", qw(3), 32'h00454600);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
